// File: rtl/oric_tape_pkg.sv
// Shared types and default timing for the Oric cassette playback block.
package oric_tape_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam int DEF_T_SHORT = 208;
    localparam int DEF_T_LONG  = 416;
    localparam int DEF_N_STOP  = 4;
    localparam int FRAME_LEN   = 10 + DEF_N_STOP;

    // start + 8 data + parity + stop bits
    function automatic int frame_len(input int n_stop);
        return 10 + n_stop;
    endfunction

endpackage

// File: rtl/tape_bit_gen.sv
// One-bit waveform generator: a high phase of T_SHORT ticks followed by a
// low phase of T_SHORT (bit 1) or T_LONG (bit 0) ticks.
module tape_bit_gen #(
    parameter int T_SHORT = 208,
    parameter int T_LONG  = 416
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    input  logic ce_i,
    input  logic start_i,
    input  logic bit_i,
    output logic ready_o,
    output logic low_o,
    output logic hi_exp_o,
    output logic lo_exp_o
);
    localparam logic [1:0] P_IDLE = 2'd0;
    localparam logic [1:0] P_HIGH = 2'd1;
    localparam logic [1:0] P_LOW  = 2'd2;

    logic [1:0]  phase_q, phase_d;
    logic [15:0] cnt_q, cnt_d;
    logic        bit_q, bit_d;
    logic        tick, zero;

    assign tick     = en_i & ce_i;
    assign zero     = (cnt_q == 16'd0);
    assign hi_exp_o = (phase_q == P_HIGH) & tick & zero;
    assign lo_exp_o = (phase_q == P_LOW) & tick & zero;
    // A new bit may be loaded on the same edge the previous low phase ends.
    assign ready_o  = (phase_q == P_IDLE) | lo_exp_o;
    assign low_o    = (phase_q == P_LOW);

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        if (clr_i) begin
            phase_d = P_IDLE;
            cnt_d   = 16'd0;
        end else if (start_i && ready_o) begin
            phase_d = P_HIGH;
            cnt_d   = 16'(T_SHORT - 1);
            bit_d   = bit_i;
        end else if (hi_exp_o) begin
            phase_d = P_LOW;
            cnt_d   = bit_q ? 16'(T_SHORT - 1) : 16'(T_LONG - 1);
        end else if (lo_exp_o) begin
            phase_d = P_IDLE;
            cnt_d   = 16'd0;
        end else if (tick && phase_q != P_IDLE) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= P_IDLE;
            cnt_q   <= 16'd0;
            bit_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
        end
    end

endmodule

// File: rtl/tape_player.sv
// Streams TAP bytes out as Oric cassette frames: framing, stream handshake
// and byte counting around the tape_bit_gen phase timer.
module tape_player
    import oric_tape_pkg::*;
#(
    parameter int T_SHORT = DEF_T_SHORT,
    parameter int T_LONG  = DEF_T_LONG,
    parameter int N_STOP  = DEF_N_STOP
) (
    input  logic        CLK_IN,
    input  logic        RESETn,
    input  logic        ce,
    input  logic        play,
    input  logic        motor,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic        tape_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] byte_count
);
    localparam int FL = frame_len(N_STOP);
    localparam int IW = $clog2(FL + 1);

    state_e        state_q, state_d;
    logic [FL-2:0] frame_q, frame_d;
    logic          last_q, last_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [15:0]   cnt_q, cnt_d;

    logic accept, final_bit;
    logic gen_start, gen_bit, gen_ready, gen_low, hi_exp, lo_exp;

    // Abort wins over a same-cycle byte offer; pause blocks the handshake.
    assign accept    = (state_q == S_FETCH) & s_valid & play & motor;
    assign final_bit = (idx_q == IW'(FL - 1));
    assign gen_start = accept | (lo_exp & ~final_bit);
    assign gen_bit   = accept ? 1'b0 : frame_q[0];

    tape_bit_gen #(
        .T_SHORT (T_SHORT),
        .T_LONG  (T_LONG)
    ) u_bit_gen (
        .clk_i    (CLK_IN),
        .rst_ni   (RESETn),
        .clr_i    (~play),
        .en_i     (motor),
        .ce_i     (ce),
        .start_i  (gen_start),
        .bit_i    (gen_bit),
        .ready_o  (gen_ready),
        .low_o    (gen_low),
        .hi_exp_o (hi_exp),
        .lo_exp_o (lo_exp)
    );

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        last_d  = last_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (!play) begin
            state_d = S_IDLE;
        end else if (motor) begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_FETCH;
                    cnt_d   = 16'd0;
                end
                S_FETCH: begin
                    if (accept && gen_ready) begin
                        state_d = S_HIGH;
                        frame_d = {{N_STOP{1'b1}}, ~^s_data, s_data};
                        last_d  = s_last;
                        idx_d   = '0;
                        cnt_d   = cnt_q + 16'd1;
                    end
                end
                S_HIGH: begin
                    if (hi_exp) state_d = S_LOW;
                end
                S_LOW: begin
                    if (lo_exp) begin
                        if (!final_bit) begin
                            state_d = S_HIGH;
                            idx_d   = idx_q + IW'(1);
                            frame_d = frame_q >> 1;
                        end else begin
                            state_d = last_q ? S_DONE : S_FETCH;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_IN or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= S_IDLE;
            frame_q <= '0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s_ready    = accept;
    assign tape_out   = ~gen_low;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign byte_count = cnt_q;

endmodule

// File: tb/tb_tape_player.sv
// Directed bench for tape_player: frame timing, parity, starvation,
// pause, abort and asynchronous reset.
module tb_tape_player;

    logic        CLK_IN = 1'b0;
    logic        RESETn = 1'b0;
    logic        ce = 1'b1;
    logic        play = 1'b0;
    logic        motor = 1'b1;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        tape_out;
    logic        busy;
    logic        done;
    logic [15:0] byte_count;

    int checks = 0;
    int passed = 0;

    localparam int TS = 208;
    localparam int TL = 416;
    localparam int NBITS = 14;

    tape_player dut (
        .CLK_IN     (CLK_IN),
        .RESETn     (RESETn),
        .ce         (ce),
        .play       (play),
        .motor      (motor),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .tape_out   (tape_out),
        .busy       (busy),
        .done       (done),
        .byte_count (byte_count)
    );

    always #5 CLK_IN = ~CLK_IN;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic fbit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
        if (i == 9) return ($countones(d) % 2 == 0);
        return 1'b1;
    endfunction

    // Count negedge samples while tape_out holds v (bounded).
    task automatic measure(input logic v, output int n);
        n = 0;
        while (tape_out === v && n < 5000) begin
            n++;
            @(negedge CLK_IN);
        end
    endtask

    // Called at a negedge; returns at the first sample after acceptance.
    task automatic send(input logic [7:0] d, input logic last);
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        #1 chk("s_ready_on_offer", {31'd0, s_ready}, 32'd1);
        @(posedge CLK_IN);
        #1 s_valid = 1'b0;
        @(negedge CLK_IN);
    endtask

    task automatic frame(input logic [7:0] d, input string tag);
        int hi, lo, exp_lo;
        for (int i = 0; i < NBITS; i++) begin
            measure(1'b1, hi);
            measure(1'b0, lo);
            exp_lo = fbit(d, i) ? TS : TL;
            checks++;
            assert (hi == TS && lo == exp_lo) passed++;
            else $error("FAIL %s bit%0d: observed hi=%0d lo=%0d expected hi=%0d lo=%0d",
                        tag, i, hi, lo, TS, exp_lo);
        end
    endtask

    initial begin
        int n, m, bad;

        #12;
        chk("rst_tape", {31'd0, tape_out}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_count", {16'd0, byte_count}, 32'd0);
        @(negedge CLK_IN);
        RESETn = 1'b1;

        play = 1'b1;
        @(negedge CLK_IN);
        chk("fetch_busy", {31'd0, busy}, 32'd1);
        chk("fetch_tape", {31'd0, tape_out}, 32'd1);
        chk("fetch_ready_idle", {31'd0, s_ready}, 32'd0);

        send(8'h00, 1'b1);
        frame(8'h00, "byte00");
        chk("b00_done", {31'd0, done}, 32'd1);
        chk("b00_count", {16'd0, byte_count}, 32'd1);
        @(negedge CLK_IN);
        chk("b00_done_off", {31'd0, done}, 32'd0);
        chk("b00_idle", {31'd0, busy}, 32'd0);
        play = 1'b0;
        @(negedge CLK_IN);

        play = 1'b1;
        @(negedge CLK_IN);
        send(8'h00, 1'b0);
        measure(1'b1, n);
        chk("pause_hi", n, TS);
        n = 0;
        repeat (100) begin
            n++;
            @(negedge CLK_IN);
        end
        motor = 1'b0;
        bad = 0;
        repeat (500) begin
            if (tape_out !== 1'b0) bad++;
            n++;
            @(negedge CLK_IN);
        end
        motor = 1'b1;
        measure(1'b0, m);
        chk("pause_tape_low", bad, 0);
        chk("pause_low_len", n + m, TL + 500);

        repeat (50) @(negedge CLK_IN);
        play = 1'b0;
        @(negedge CLK_IN);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_tape", {31'd0, tape_out}, 32'd1);
        chk("abort_done", {31'd0, done}, 32'd0);
        play = 1'b1;
        @(negedge CLK_IN);
        chk("restart_busy", {31'd0, busy}, 32'd1);
        chk("restart_count", {16'd0, byte_count}, 32'd0);

        send(8'h01, 1'b0);
        frame(8'h01, "byte01");
        bad = 0;
        repeat (1000) begin
            if (tape_out !== 1'b1 || s_ready !== 1'b0) bad++;
            @(negedge CLK_IN);
        end
        chk("gap_idle_line", bad, 0);
        chk("gap_count", {16'd0, byte_count}, 32'd1);
        send(8'hA5, 1'b1);
        frame(8'hA5, "byteA5");
        chk("a5_done", {31'd0, done}, 32'd1);
        chk("a5_count", {16'd0, byte_count}, 32'd2);
        @(negedge CLK_IN);
        play = 1'b0;
        @(negedge CLK_IN);

        play = 1'b1;
        @(negedge CLK_IN);
        motor   = 1'b0;
        s_data  = 8'h55;
        s_last  = 1'b1;
        s_valid = 1'b1;
        #1 chk("paused_ready", {31'd0, s_ready}, 32'd0);
        @(negedge CLK_IN);
        chk("paused_count", {16'd0, byte_count}, 32'd0);
        motor = 1'b1;
        play  = 1'b0;
        #1 chk("abort_win_ready", {31'd0, s_ready}, 32'd0);
        @(negedge CLK_IN);
        chk("abort_win_busy", {31'd0, busy}, 32'd0);
        chk("abort_win_count", {16'd0, byte_count}, 32'd0);
        s_valid = 1'b0;

        play = 1'b1;
        @(negedge CLK_IN);
        send(8'h00, 1'b1);
        repeat (50) @(negedge CLK_IN);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 RESETn = 1'b0;
        #1;
        chk("arst_tape", {31'd0, tape_out}, 32'd1);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_ready", {31'd0, s_ready}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_count", {16'd0, byte_count}, 32'd0);
        play = 1'b0;
        @(negedge CLK_IN);
        RESETn = 1'b1;
        @(negedge CLK_IN);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
